tournament_index_decoder: RTL and testbench
===========================================

Name: tournament_index_decoder

Overview:
- Consumes the per-layer compare_result vectors of a 32-input max-comparator tournament (layers 32->16->8->4->2->1).
- Walks the tree from root to leaf, one layer per clock, and recovers the original 5-bit index of the maximum.
- Tracks ranks 0..TOPK-1 for the select-top-K flow.
- Sits after the comparator tree and feeds the index-masking and readout stage.

Parameters:
- N_IN, 32, tournament width; power of two.
- IDX_W, $clog2(N_IN) = 5, index width and number of tree layers.
- TOPK, 6, decodes per selection round.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  compare vectors valid.
- in_ready  output  1  decoder can accept a tree.
- cmp_l1  input  16  layer-1 results; bit j covers pair (2j, 2j+1).
- cmp_l2  input  8  layer-2 results.
- cmp_l3  input  4  layer-3 results.
- cmp_l4  input  2  layer-4 results.
- cmp_l5  input  1  root result.
- idx_valid  output  1  decoded index available.
- idx_ready  input  1  downstream accepts the index.
- idx_out  output  5  winner's original input index.
- rank_out  output  3  rank of idx_out in the current round, 0..TOPK-1.
- sel_mask  output  32  one-hot accumulation of indices emitted this round.
- round_done  output  1  one-cycle pulse after the TOPK-th index is accepted.
- dup_err  output  1  sticky flag: a decoded index was already in sel_mask.

Behaviour:
- Bit convention:
  - cmp bit = 1: the even input (in_value_a) won, so the child is 2p.
  - cmp bit = 0: the odd input won, so the child is 2p+1.
- Reset: all registers clear; state IDLE; idx_valid=0, idx_out=0, rank_out=0, sel_mask=0, round_done=0, dup_err=0.
- in_ready = (state==IDLE), so it reads 1 in the first cycle after reset.
- FSM states:
  - IDLE: on in_valid&in_ready, latch all five vectors, set p=0 and layer=5, go to WALK.
  - WALK: each cycle, p <= {p, ~cmp_lL[p]} and the layer decrements. After the layer-1 step, go to EMIT.
  - EMIT: idx_valid=1 with idx_out=p and rank_out=rank, all held stable until idx_ready.
- On acceptance in EMIT (idx_valid&idx_ready):
  - sel_mask[p] <= 1; rank increments.
  - If the new rank == TOPK: clear rank and sel_mask, pulse round_done in the next cycle.
  - Return to IDLE.
- Latency: accept edge to idx_valid high is 6 cycles (5 WALK cycles + 1 to enter EMIT).
- Throughput: one tree per 7 cycles minimum, when idx_ready is already high.
- Input vectors are latched; inputs may change after the handshake.
- Within a layer, the index used is p's current value. The layer-L vector has 2^(5-L) bits, and p is always within range.
- Simultaneous round_done pulse and a new in_valid: acceptance is allowed, since in_ready=1 in IDLE.
- idx_ready held high before EMIT: no effect until EMIT.
- Reset mid-WALK or mid-EMIT: in-flight decode discarded; rank, sel_mask and dup_err cleared.
- dup_err sets when EMIT is entered with sel_mask[p] already 1. It clears only on rst. The duplicate index is still emitted normally.

Optional Feature:
- Macro: TOURNAMENT_DUP_CHECK_EN.
- Defined: dup_err behaves as above.
- Undefined: the dup_err output is tied to 0, with no mask lookup logic; sel_mask is still maintained.

Decomposition:
- Package tournament_pkg holds:
  - constants N_IN=32, IDX_W=5, TOPK=6, VAL_W=13;
  - typedef idx_t (logic [IDX_W-1:0]);
  - the FSM enum dec_state_e {IDLE, WALK, EMIT}.
- One natural sub-module: tournament_layer_mux. It is combinational and selects cmp bit p from the latched vector of the current layer. It keeps the FSM file free of width-varying indexing.

Test Plan:
- All cmp vectors all-ones -> after 6 cycles idx_out=0, rank_out=0; after accept, sel_mask=32'h0000_0001.
- All cmp vectors all-zeros -> idx_out=31; after accept, sel_mask=32'h8000_0000.
- All ones except cmp_l1[0]=0 -> idx_out=1.
- cmp_l5=0, cmp_l4=2'b11, cmp_l3=4'b1111, cmp_l2=8'hFF, cmp_l1=16'hFFFF -> idx_out=16.
- Six distinct trees decoding to 0,1,2,3,4,5, idx_ready always high:
  - rank_out runs 0..5;
  - round_done pulses once, the cycle after the 6th accept;
  - sel_mask then reads 0.
- The same tree (idx 7) sent twice in one round -> dup_err=1 from the second EMIT, sticky until rst.
  - Without TOURNAMENT_DUP_CHECK_EN, dup_err stays 0.
- idx_ready held low 10 cycles in EMIT -> idx_out and rank_out stable, in_ready=0.
  - rst asserted in cycle 3 of WALK -> next cycle in_ready=1, idx_valid=0, rank and mask cleared.

Source files
------------

// File: rtl/tournament_index_decoder_pkg.sv
// Shared types and constants for the tournament index decoder.
// Optional duplicate detection: TOURNAMENT_DUP_CHECK_EN.
package tournament_pkg;

    localparam int N_IN   = 32;
    localparam int IDX_W  = 5;
    localparam int TOPK   = 6;
    localparam int VAL_W  = 13;
    localparam int RANK_W = 3;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [RANK_W-1:0] rank_t;
    typedef logic [2:0]        layer_t;

    localparam rank_t  TOPK_R    = rank_t'(TOPK);
    localparam layer_t ROOT_L    = layer_t'(IDX_W);
    localparam layer_t LEAF_L    = 3'd1;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        EMIT
    } dec_state_e;

    typedef struct packed {
        logic [15:0] l1;
        logic [7:0]  l2;
        logic [3:0]  l3;
        logic [1:0]  l4;
        logic        l5;
    } cmp_vec_t;

    function automatic logic [N_IN-1:0] idx_onehot(input idx_t i);
        return N_IN'(1) << i;
    endfunction

endpackage

// File: rtl/tournament_index_decoder_layer_mux.sv
// Picks compare bit p out of the latched vector of the current layer.
// Only the low IDX_W-1 path bits can address any layer.
module tournament_layer_mux
    import tournament_pkg::*;
(
    input  cmp_vec_t           i_vec,
    input  layer_t             i_layer,
    input  logic [IDX_W-2:0]   i_p,
    output logic               o_bit
);

    always_comb begin
        o_bit = 1'b0;
        unique case (i_layer)
            3'd5:    o_bit = i_vec.l5;
            3'd4:    o_bit = i_vec.l4[i_p[0]];
            3'd3:    o_bit = i_vec.l3[i_p[1:0]];
            3'd2:    o_bit = i_vec.l2[i_p[2:0]];
            3'd1:    o_bit = i_vec.l1[i_p[3:0]];
            default: o_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/tournament_index_decoder.sv
// Root-to-leaf walk of a 32-input max tournament, one layer per clock.
// Duplicate detection is built only with TOURNAMENT_DUP_CHECK_EN.
module tournament_index_decoder
    import tournament_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [15:0]     i_cmp_l1,
    input  logic [7:0]      i_cmp_l2,
    input  logic [3:0]      i_cmp_l3,
    input  logic [1:0]      i_cmp_l4,
    input  logic            i_cmp_l5,
    output logic            o_idx_valid,
    input  logic            i_idx_ready,
    output idx_t            o_idx_out,
    output rank_t           o_rank_out,
    output logic [N_IN-1:0] o_sel_mask,
    output logic            o_round_done,
    output logic            o_dup_err
);

    dec_state_e      r_state;
    cmp_vec_t        r_vec;
    layer_t          r_layer;
    idx_t            r_p;
    rank_t           r_rank;
    logic [N_IN-1:0] r_mask;
    logic            r_idx_valid;
    logic            r_round_done;

    logic            w_bit;
    idx_t            w_p_next;
    rank_t           w_rank_inc;
    logic            w_enter_emit;

    tournament_layer_mux u_mux (
        .i_vec   (r_vec),
        .i_layer (r_layer),
        .i_p     (r_p[IDX_W-2:0]),
        .o_bit   (w_bit)
    );

    // A set compare bit means the even child won.
    assign w_p_next     = {r_p[IDX_W-2:0], ~w_bit};
    assign w_rank_inc   = r_rank + 1'b1;
    assign w_enter_emit = (r_state == WALK) && (r_layer == LEAF_L);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_vec        <= '0;
            r_layer      <= '0;
            r_p          <= '0;
            r_rank       <= '0;
            r_mask       <= '0;
            r_idx_valid  <= 1'b0;
            r_round_done <= 1'b0;
        end else begin
            r_round_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_vec   <= '{l1: i_cmp_l1,
                                     l2: i_cmp_l2,
                                     l3: i_cmp_l3,
                                     l4: i_cmp_l4,
                                     l5: i_cmp_l5};
                        r_p     <= '0;
                        r_layer <= ROOT_L;
                        r_state <= WALK;
                    end
                end
                WALK: begin
                    r_p     <= w_p_next;
                    r_layer <= r_layer - 3'd1;
                    if (r_layer == LEAF_L) begin
                        r_state     <= EMIT;
                        r_idx_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (i_idx_ready) begin
                        r_idx_valid <= 1'b0;
                        r_state     <= IDLE;
                        if (w_rank_inc == TOPK_R) begin
                            r_rank       <= '0;
                            r_mask       <= '0;
                            r_round_done <= 1'b1;
                        end else begin
                            r_rank <= w_rank_inc;
                            r_mask <= r_mask | idx_onehot(r_p);
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_idx_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef TOURNAMENT_DUP_CHECK_EN
    logic r_dup_err;

    // Checked against the mask as it stands when the index first appears.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dup_err <= 1'b0;
        end else if (w_enter_emit && r_mask[w_p_next]) begin
            r_dup_err <= 1'b1;
        end
    end

    assign o_dup_err = r_dup_err;
`else
    logic w_unused_emit;

    assign w_unused_emit = w_enter_emit;
    assign o_dup_err     = 1'b0;
`endif

    assign o_in_ready   = (r_state == IDLE);
    assign o_idx_valid  = r_idx_valid;
    assign o_idx_out    = r_p;
    assign o_rank_out   = r_rank;
    assign o_sel_mask   = r_mask;
    assign o_round_done = r_round_done;

endmodule

// File: tb/tb_tournament_index_decoder.sv
// Directed bench for tournament_index_decoder.
module tb_tournament_index_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] cmp_l1;
    logic [7:0]  cmp_l2;
    logic [3:0]  cmp_l3;
    logic [1:0]  cmp_l4;
    logic        cmp_l5;
    logic        idx_valid;
    logic        idx_ready;
    logic [4:0]  idx_out;
    logic [2:0]  rank_out;
    logic [31:0] sel_mask;
    logic        round_done;
    logic        dup_err;

    int checks;
    int fails;

`ifdef TOURNAMENT_DUP_CHECK_EN
    localparam logic EXP_DUP = 1'b1;
`else
    localparam logic EXP_DUP = 1'b0;
`endif

    tournament_index_decoder dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_cmp_l1     (cmp_l1),
        .i_cmp_l2     (cmp_l2),
        .i_cmp_l3     (cmp_l3),
        .i_cmp_l4     (cmp_l4),
        .i_cmp_l5     (cmp_l5),
        .o_idx_valid  (idx_valid),
        .i_idx_ready  (idx_ready),
        .o_idx_out    (idx_out),
        .o_rank_out   (rank_out),
        .o_sel_mask   (sel_mask),
        .o_round_done (round_done),
        .o_dup_err    (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Hand a tree over, scramble the inputs, then wait for the EMIT state.
    task automatic send(input string tag,
                        input logic [15:0] l1,
                        input logic [7:0]  l2,
                        input logic [3:0]  l3,
                        input logic [1:0]  l4,
                        input logic        l5,
                        input logic [4:0]  ei,
                        input logic [2:0]  er);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        cmp_l1 = l1;
        cmp_l2 = l2;
        cmp_l3 = l3;
        cmp_l4 = l4;
        cmp_l5 = l5;
        step();
        in_valid = 1'b0;
        cmp_l1 = 16'($urandom);
        cmp_l2 = 8'($urandom);
        cmp_l3 = 4'($urandom);
        cmp_l4 = 2'($urandom);
        cmp_l5 = 1'($urandom);
        n = 1;
        while (!idx_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd6);
        check({tag, "_idx"}, 32'(idx_out), 32'(ei));
        check({tag, "_rank"}, 32'(rank_out), 32'(er));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
    endtask

    logic [15:0] t_l1 [6];
    logic [7:0]  t_l2 [6];
    logic [3:0]  t_l3 [6];
    logic [31:0] t_mask [6];

    initial begin
        checks = 0;
        fails = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        idx_ready = 1'b0;
        cmp_l1 = '0;
        cmp_l2 = '0;
        cmp_l3 = '0;
        cmp_l4 = '0;
        cmp_l5 = 1'b0;

        t_l1 = '{16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hFFFD, 16'hFFFF, 16'hFFFB};
        t_l2 = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFF, 8'hFF};
        t_l3 = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 4'hE};
        t_mask = '{32'h1, 32'h3, 32'h7, 32'hF, 32'h1F, 32'h0};

        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_idx_valid", 32'(idx_valid), 32'd0);
        check("rst_idx_out", 32'(idx_out), 32'd0);
        check("rst_rank", 32'(rank_out), 32'd0);
        check("rst_mask", sel_mask, 32'd0);
        check("rst_round_done", 32'(round_done), 32'd0);
        check("rst_dup", 32'(dup_err), 32'd0);

        idx_ready = 1'b1;
        send("ones", 16'hFFFF, 8'hFF, 4'hF, 2'b11, 1'b1, 5'd0, 3'd0);
        step();
        check("ones_mask", sel_mask, 32'h0000_0001);

        do_reset();
        send("zeros", 16'h0000, 8'h00, 4'h0, 2'b00, 1'b0, 5'd31, 3'd0);
        step();
        check("zeros_mask", sel_mask, 32'h8000_0000);

        do_reset();
        send("leaf1", 16'hFFFE, 8'hFF, 4'hF, 2'b11, 1'b1, 5'd1, 3'd0);
        step();
        send("root0", 16'hFFFF, 8'hFF, 4'hF, 2'b11, 1'b0, 5'd16, 3'd1);
        step();
        check("root0_mask", sel_mask, 32'h0001_0002);
        send("sparse22", 16'h0800, 8'h00, 4'hB, 2'b10, 1'b0, 5'd22, 3'd2);
        step();
        check("sparse22_mask", sel_mask, 32'h0041_0002);

        do_reset();
        for (int k = 0; k < 6; k++) begin
            send($sformatf("round_%0d", k), t_l1[k], t_l2[k], t_l3[k],
                 2'b11, 1'b1, 5'(k), 3'(k));
            step();
            check($sformatf("round_done_%0d", k), 32'(round_done),
                  (k == 5) ? 32'd1 : 32'd0);
            check($sformatf("round_mask_%0d", k), sel_mask, t_mask[k]);
        end
        check("round_rank_wrap", 32'(rank_out), 32'd0);
        step();
        check("round_done_pulse", 32'(round_done), 32'd0);

        do_reset();
        send("dup_a", 16'hFFF7, 8'hFD, 4'hE, 2'b11, 1'b1, 5'd7, 3'd0);
        check("dup_first", 32'(dup_err), 32'd0);
        step();
        send("dup_b", 16'hFFF7, 8'hFD, 4'hE, 2'b11, 1'b1, 5'd7, 3'd1);
        check("dup_second", 32'(dup_err), 32'(EXP_DUP));
        step();
        check("dup_mask", sel_mask, 32'h0000_0080);
        send("dup_c", 16'hFFFF, 8'hFF, 4'hF, 2'b11, 1'b1, 5'd0, 3'd2);
        check("dup_sticky", 32'(dup_err), 32'(EXP_DUP));
        step();
        do_reset();
        check("dup_cleared", 32'(dup_err), 32'd0);

        idx_ready = 1'b0;
        send("stall", 16'hFFFB, 8'hFF, 4'hE, 2'b11, 1'b1, 5'd5, 3'd0);
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("stall_valid_%0d", c), 32'(idx_valid), 32'd1);
            check($sformatf("stall_idx_%0d", c), 32'(idx_out), 32'd5);
            check($sformatf("stall_rank_%0d", c), 32'(rank_out), 32'd0);
            check($sformatf("stall_busy_%0d", c), 32'(in_ready), 32'd0);
        end
        idx_ready = 1'b1;
        step();
        check("stall_mask", sel_mask, 32'h0000_0020);
        check("stall_rank", 32'(rank_out), 32'd1);
        check("stall_done_valid", 32'(idx_valid), 32'd0);
        check("stall_idle", 32'(in_ready), 32'd1);

        in_valid = 1'b1;
        cmp_l1 = 16'h0000;
        cmp_l2 = 8'h00;
        cmp_l3 = 4'h0;
        cmp_l4 = 2'b00;
        cmp_l5 = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_valid", 32'(idx_valid), 32'd0);
        check("midrst_rank", 32'(rank_out), 32'd0);
        check("midrst_mask", sel_mask, 32'd0);
        repeat (8) step();
        check("midrst_no_emit", 32'(idx_valid), 32'd0);

        send("recover", 16'h0000, 8'h00, 4'h0, 2'b00, 1'b0, 5'd31, 3'd0);
        step();
        check("recover_mask", sel_mask, 32'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
